// File: rtl/pool_scheduler.sv
// pool_scheduler
//   Time-multiplexed 2x2 / stride-2 max pooling over CHANNELS feature maps held
//   in a single-port feature buffer. One read per cycle, one comparator; each
//   window produces one pooled word written to the pooled-result buffer.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        one-cycle request to pool all channels (ignored unless idle)
//   busy         high from the cycle after start is accepted through the done cycle
//   done         one-cycle pulse after the final write is accepted
//   rd_en        feature-buffer read strobe
//   rd_addr      c*IN_X*IN_Y + row*IN_Y + col
//   rd_data      signed feature word, valid one cycle after rd_en
//   wr_en        pooled word valid (held until wr_ready)
//   wr_addr      c*OUT_X*OUT_Y + px*OUT_Y + py
//   wr_data      signed pooled maximum (floored at 0)
//   wr_ready     sink accepts the word when wr_en && wr_ready
module pool_scheduler #(
    parameter int DATA_WIDTH    = 69,
    parameter int IN_X          = 24,
    parameter int IN_Y          = 24,
    parameter int STRIDE        = 2,
    parameter int CHANNELS      = 8,
    parameter int RD_ADDR_WIDTH = 13,
    parameter int WR_ADDR_WIDTH = 11
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            rd_en,
    output logic [RD_ADDR_WIDTH-1:0]        rd_addr,
    input  logic signed [DATA_WIDTH-1:0]    rd_data,
    output logic                            wr_en,
    output logic [WR_ADDR_WIDTH-1:0]        wr_addr,
    output logic signed [DATA_WIDTH-1:0]    wr_data,
    input  logic                            wr_ready
);

    localparam int OUT_X = IN_X / STRIDE;
    localparam int OUT_Y = IN_Y / STRIDE;
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int XW    = (OUT_X > 1)    ? $clog2(OUT_X)    : 1;
    localparam int YW    = (OUT_Y > 1)    ? $clog2(OUT_Y)    : 1;
    localparam int SW    = (STRIDE > 1)   ? $clog2(STRIDE)   : 1;
    localparam logic [WR_ADDR_WIDTH-1:0] WR_LAST = WR_ADDR_WIDTH'(CHANNELS*OUT_X*OUT_Y - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                      state;
    logic                        issue_q;
    logic                        stall;
    logic [CW-1:0]               c_q;
    logic [XW-1:0]               px_q;
    logic [YW-1:0]               py_q;
    logic [SW-1:0]               sr_q;   // row offset inside the window
    logic [SW-1:0]               sc_q;   // column offset inside the window
    logic                        first_slot, last_slot, last_win, last_read;
    logic [RD_ADDR_WIDTH-1:0]    row, col;
    logic [WR_ADDR_WIDTH-1:0]    cur_waddr;

    // read-data stage: tags travelling alongside the outstanding read
    logic                        rd_vld;
    logic                        first_d, last_d;
    logic [WR_ADDR_WIDTH-1:0]    wa_d;
    logic signed [DATA_WIDTH-1:0] max_q, max_base, max_nxt;

    // A held, unaccepted write blocks new reads; this keeps the output
    // register free by the time the next window can possibly complete.
    assign stall = wr_en && !wr_ready;
    assign rd_en = issue_q && !stall;

    assign first_slot = (sr_q == '0) && (sc_q == '0);
    assign last_slot  = (sr_q == SW'(STRIDE-1)) && (sc_q == SW'(STRIDE-1));
    assign last_win   = (c_q == CW'(CHANNELS-1)) && (px_q == XW'(OUT_X-1)) &&
                        (py_q == YW'(OUT_Y-1));
    assign last_read  = last_slot && last_win;

    always_comb begin
        row       = RD_ADDR_WIDTH'(px_q) * RD_ADDR_WIDTH'(STRIDE) + RD_ADDR_WIDTH'(sr_q);
        col       = RD_ADDR_WIDTH'(py_q) * RD_ADDR_WIDTH'(STRIDE) + RD_ADDR_WIDTH'(sc_q);
        rd_addr   = RD_ADDR_WIDTH'(c_q) * RD_ADDR_WIDTH'(IN_X*IN_Y) +
                    row * RD_ADDR_WIDTH'(IN_Y) + col;
        cur_waddr = WR_ADDR_WIDTH'(c_q) * WR_ADDR_WIDTH'(OUT_X*OUT_Y) +
                    WR_ADDR_WIDTH'(px_q) * WR_ADDR_WIDTH'(OUT_Y) + WR_ADDR_WIDTH'(py_q);
    end

    // Control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            issue_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_RUN;
                    busy    <= 1'b1;
                    issue_q <= 1'b1;
                end
                S_RUN: if (rd_en && last_read) begin
                    state   <= S_DRAIN;
                    issue_q <= 1'b0;
                end
                S_DRAIN: if (wr_en && wr_ready && wr_addr == WR_LAST) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read counters: column offset innermost, then row offset, py, px, channel.
    // All wrap to 0 after the last read, so the next job starts at window 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q  <= '0;
            px_q <= '0;
            py_q <= '0;
            sr_q <= '0;
            sc_q <= '0;
        end else if (rd_en) begin
            if (sc_q == SW'(STRIDE-1)) begin
                sc_q <= '0;
                if (sr_q == SW'(STRIDE-1)) begin
                    sr_q <= '0;
                    if (py_q == YW'(OUT_Y-1)) begin
                        py_q <= '0;
                        if (px_q == XW'(OUT_X-1)) begin
                            px_q <= '0;
                            c_q  <= (c_q == CW'(CHANNELS-1)) ? '0 : c_q + 1'b1;
                        end else begin
                            px_q <= px_q + 1'b1;
                        end
                    end else begin
                        py_q <= py_q + 1'b1;
                    end
                end else begin
                    sr_q <= sr_q + 1'b1;
                end
            end else begin
                sc_q <= sc_q + 1'b1;
            end
        end
    end

    // Running max starts from 0 on each window's first datum, so negative
    // windows pool to 0; strict '>' keeps the earlier value on ties.
    always_comb begin
        max_base = first_d ? '0 : max_q;
        max_nxt  = (rd_data > max_base) ? rd_data : max_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld  <= 1'b0;
            first_d <= 1'b0;
            last_d  <= 1'b0;
            wa_d    <= '0;
            max_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                first_d <= first_slot;
                last_d  <= last_slot;
                wa_d    <= cur_waddr;
            end
            if (rd_vld) max_q <= max_nxt;
            if (wr_en && wr_ready) wr_en <= 1'b0;
            // completion may coincide with acceptance of the previous word
            if (rd_vld && last_d) begin
                wr_en   <= 1'b1;
                wr_data <= max_nxt;
                wr_addr <= wa_d;
            end
        end
    end

endmodule

// File: tb/tb_pool_scheduler.sv
// Testbench for pool_scheduler: feature-buffer model, pooled-write capture and
// a window-max reference model computed directly from the buffer contents.
module tb_pool_scheduler;

    localparam int DW   = 69;
    localparam int N_RD = 4608;
    localparam int N_WR = 1152;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  wr_ready = 1'b1;
    logic                  busy, done, rd_en, wr_en;
    logic [12:0]           rd_addr;
    logic [10:0]           wr_addr;
    logic signed [DW-1:0]  rd_data = '0;
    logic signed [DW-1:0]  wr_data;

    logic signed [DW-1:0]  mem [N_RD];
    logic signed [DW-1:0]  exp_data [N_WR];
    logic [10:0]           cap_addr [$];
    logic signed [DW-1:0]  cap_data [$];

    int checks = 0;
    int errors = 0;
    int ecnt = 0;
    int e0 = 0;
    int done_cnt, done_cyc, first_wr_cyc, first_rd_cyc, last_rd_cyc, stall_bad;

    pool_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // single-port feature buffer, one-cycle read latency
    always @(posedge clk)
        if (rd_en) rd_data <= (int'(rd_addr) < N_RD) ? mem[rd_addr] : '0;

    // monitor: cycle k is the k-th cycle after the edge that sampled start
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en && wr_ready) begin
                cap_addr.push_back(wr_addr);
                cap_data.push_back(wr_data);
                if (first_wr_cyc < 0) first_wr_cyc = ecnt - e0 + 1;
            end
            if (rd_en) begin
                if (first_rd_cyc < 0) first_rd_cyc = ecnt - e0 + 1;
                last_rd_cyc = ecnt - e0 + 1;
            end
            if (wr_en && !wr_ready && rd_en) stall_bad++;
            if (done) begin
                done_cnt++;
                done_cyc = ecnt - e0 + 1;
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < N_RD; i++) mem[i] = DW'(i);
    endtask

    task automatic fill_random();
        logic [95:0] r;
        for (int i = 0; i < N_RD; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            mem[i] = $signed(r[DW-1:0]);
        end
    endtask

    // pooled word = max(0, four window values), written in c/px/py order
    task automatic build_model();
        logic signed [DW-1:0] m, v;
        for (int c = 0; c < 8; c++)
            for (int px = 0; px < 12; px++)
                for (int py = 0; py < 12; py++) begin
                    m = '0;
                    for (int k = 0; k < 4; k++) begin
                        v = mem[c*576 + (2*px + k/2)*24 + 2*py + k%2];
                        if (v > m) m = v;
                    end
                    exp_data[c*144 + px*12 + py] = m;
                end
    endtask

    function automatic int first_bad();
        for (int i = 0; i < N_WR && i < cap_addr.size(); i++)
            if (cap_addr[i] !== 11'(i) || cap_data[i] !== exp_data[i]) return i;
        return -1;
    endfunction

    task automatic clear_stats();
        cap_addr.delete();
        cap_data.delete();
        done_cnt = 0; done_cyc = -1; first_wr_cyc = -1;
        first_rd_cyc = -1; last_rd_cyc = -1; stall_bad = 0;
    endtask

    task automatic start_job();
        clear_stats();
        @(negedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        e0 = ecnt;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk); #1;
            if (rnd) wr_ready = ($urandom_range(0, 3) != 0);
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
        wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (rd_en !== 1'b0)   begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        checks++; if (rd_addr !== '0)   begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
        checks++; if (wr_en !== 1'b0)   begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        checks++; if (wr_addr !== '0)   begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
        checks++; if (wr_data !== '0)   begin errors++; $display("FAIL reset_wr_data: got %0d want 0", wr_data); end
        rst_n = 1'b1;
        tick_n(3);
        checks++; if (busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy=%b rd_en=%b want 0 0", busy, rd_en);
        end
    endtask

    task automatic test_ramp();
        bit ok; int b;
        fill_ramp(); build_model();
        start_job();
        wait_done(20000, 1'b0, ok);
        tick_n(5);
        checks++; if (!ok) begin errors++; $display("FAIL ramp_timeout: done not seen, want done"); end
        checks++; if (first_rd_cyc !== 1) begin errors++; $display("FAIL ramp_first_rd: got cycle %0d want 1", first_rd_cyc); end
        checks++; if (first_wr_cyc !== 6) begin errors++; $display("FAIL ramp_first_wr: got cycle %0d want 6", first_wr_cyc); end
        checks++; if (last_rd_cyc !== 4608) begin errors++; $display("FAIL ramp_last_rd: got cycle %0d want 4608", last_rd_cyc); end
        checks++; if (done_cyc !== 4611) begin errors++; $display("FAIL ramp_done_cycle: got %0d want 4611", done_cyc); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ramp_done_count: got %0d want 1", done_cnt); end
        checks++; if (cap_addr.size() !== N_WR) begin errors++; $display("FAIL ramp_write_count: got %0d want %0d", cap_addr.size(), N_WR); end
        b = first_bad();
        checks++; if (b !== -1) begin errors++; $display("FAIL ramp_sequence: got addr %0d data %0d want addr %0d data %0d", cap_addr[b], cap_data[b], b, exp_data[b]); end
        if (cap_data.size() == N_WR) begin
            checks++; if (cap_data[0] !== 69'sd25) begin errors++; $display("FAIL ramp_first_word: got %0d want 25", cap_data[0]); end
            checks++; if (cap_data[N_WR-1] !== 69'sd4607) begin errors++; $display("FAIL ramp_last_word: got %0d want 4607", cap_data[N_WR-1]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_negative_channel();
        bit ok; int b, nz;
        fill_random();
        for (int i = 3*576; i < 4*576; i++) mem[i] = -69'sd5;
        build_model();
        start_job();
        wait_done(40000, 1'b1, ok);   // random backpressure throughout
        tick_n(5);
        checks++; if (!ok) begin errors++; $display("FAIL neg_timeout: done not seen, want done"); end
        checks++; if (cap_addr.size() !== N_WR) begin errors++; $display("FAIL neg_write_count: got %0d want %0d", cap_addr.size(), N_WR); end
        b = first_bad();
        checks++; if (b !== -1) begin errors++; $display("FAIL neg_sequence: got addr %0d data %0d want addr %0d data %0d", cap_addr[b], cap_data[b], b, exp_data[b]); end
        nz = 0;
        for (int i = 0; i < cap_addr.size(); i++)
            if (cap_addr[i] >= 11'd432 && cap_addr[i] <= 11'd575 && cap_data[i] !== '0) nz++;
        checks++; if (nz !== 0) begin errors++; $display("FAIL neg_channel_zero: got %0d nonzero words want 0", nz); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL neg_read_during_stall: got %0d reads want 0", stall_bad); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL neg_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_tie_position();
        bit ok; int b;
        fill_random();
        mem[0] = 69'sd7;  mem[1] = 69'sd7;  mem[24] = 69'sd3; mem[25] = -69'sd1;
        mem[2] = 69'sd5;  mem[3] = -69'sd3; mem[26] = 69'sd9; mem[27] = 69'sd100;
        build_model();
        start_job();
        wait_done(20000, 1'b0, ok);
        tick_n(2);
        checks++; if (!ok) begin errors++; $display("FAIL tie_timeout: done not seen, want done"); end
        if (cap_data.size() >= 2) begin
            checks++; if (cap_data[0] !== 69'sd7) begin errors++; $display("FAIL tie_word0: got %0d want 7", cap_data[0]); end
            checks++; if (cap_data[1] !== 69'sd100) begin errors++; $display("FAIL tie_word1: got %0d want 100", cap_data[1]); end
        end else begin
            checks++; errors++; $display("FAIL tie_words: got %0d writes want >=2", cap_data.size());
        end
        b = first_bad();
        checks++; if (b !== -1) begin errors++; $display("FAIL tie_sequence: got addr %0d data %0d want addr %0d data %0d", cap_addr[b], cap_data[b], b, exp_data[b]); end
    endtask

    task automatic test_backpressure();
        bit ok; int b, bad;
        fill_ramp(); build_model();
        start_job();
        // now in cycle 1; advance to the start of cycle 6 (first wr_en)
        for (int n = 0; n < 20 && (ecnt - e0) < 5; n++) begin @(posedge clk); #1; end
        wr_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (wr_en !== 1'b1 || wr_addr !== 11'd0 || wr_data !== 69'sd25 || rd_en !== 1'b0) bad++;
        end
        @(posedge clk); #1 wr_ready = 1'b1;
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d bad stall cycles want 0 (wr_en=%b addr=%0d data=%0d rd_en=%b)", bad, wr_en, wr_addr, wr_data, rd_en); end
        wait_done(20000, 1'b0, ok);
        tick_n(3);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: done not seen, want done"); end
        checks++; if (done_cyc !== 4621) begin errors++; $display("FAIL bp_done_cycle: got %0d want 4621", done_cyc); end
        checks++; if (cap_addr.size() !== N_WR) begin errors++; $display("FAIL bp_write_count: got %0d want %0d", cap_addr.size(), N_WR); end
        b = first_bad();
        checks++; if (b !== -1) begin errors++; $display("FAIL bp_sequence: got addr %0d data %0d want addr %0d data %0d", cap_addr[b], cap_data[b], b, exp_data[b]); end
    endtask

    task automatic test_start_while_busy();
        bit ok; int b;
        start_job();
        for (int n = 0; n < 200 && (ecnt - e0) < 99; n++) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(20000, 1'b0, ok);
        tick_n(30);
        checks++; if (!ok) begin errors++; $display("FAIL sb_timeout: done not seen, want done"); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL sb_done_count: got %0d want 1", done_cnt); end
        checks++; if (done_cyc !== 4611) begin errors++; $display("FAIL sb_done_cycle: got %0d want 4611", done_cyc); end
        checks++; if (busy !== 1'b0 || rd_en !== 1'b0) begin errors++; $display("FAIL sb_idle_after: busy=%b rd_en=%b want 0 0", busy, rd_en); end
        b = first_bad();
        checks++; if (b !== -1 || cap_addr.size() !== N_WR) begin errors++; $display("FAIL sb_sequence: got %0d writes first bad %0d want %0d writes none bad", cap_addr.size(), b, N_WR); end
    endtask

    task automatic test_reset_mid_run();
        bit ok; int b;
        start_job();
        for (int n = 0; n < 3000 && (ecnt - e0) < 1999; n++) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;       // mid high phase, away from any clock edge
        #1;
        checks++; if (busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0) begin
            errors++; $display("FAIL mid_reset_async: busy=%b rd_en=%b wr_en=%b want 0 0 0", busy, rd_en, wr_en);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
        clear_stats();
        tick_n(5);
        checks++; if (cap_addr.size() !== 0 || wr_en !== 1'b0) begin errors++; $display("FAIL mid_no_partial: got %0d writes wr_en=%b want 0 0", cap_addr.size(), wr_en); end
        start_job();
        @(negedge clk); #1;
        checks++; if (rd_en !== 1'b1 || rd_addr !== 13'd0) begin errors++; $display("FAIL mid_first_rd: rd_en=%b addr=%0d want 1 0", rd_en, rd_addr); end
        wait_done(20000, 1'b0, ok);
        tick_n(3);
        checks++; if (!ok) begin errors++; $display("FAIL mid_timeout: done not seen, want done"); end
        if (cap_addr.size() > 0) begin
            checks++; if (cap_addr[0] !== 11'd0) begin errors++; $display("FAIL mid_first_wr: got addr %0d want 0", cap_addr[0]); end
        end
        b = first_bad();
        checks++; if (b !== -1 || cap_addr.size() !== N_WR) begin errors++; $display("FAIL mid_sequence: got %0d writes first bad %0d want %0d writes none bad", cap_addr.size(), b, N_WR); end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_ramp();
        test_negative_channel();
        test_tie_position();
        test_backpressure();
        fill_ramp(); build_model();
        test_start_while_busy();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
